// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared timer states, BCD limits and clamp helper
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] SIX_MAX = 4'd5;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] val, input logic [3:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - one BCD digit of the countdown borrow chain
module bcd_down_digit #(
  parameter logic [3:0] WRAP = 4'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dec_in,
  input  logic       load,
  input  logic [3:0] ld_val,
  output logic [3:0] digit,
  output logic       borrow_out
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= ld_val;
    end else if (dec_in) begin
      digit <= (digit == 4'd0) ? WRAP : digit - 4'd1;
    end
  end

  // A zero digit asked to decrement wraps and passes the borrow upward.
  assign borrow_out = dec_in && (digit == 4'd0);

endmodule

// File: rtl/m_cd_min_sec.sv
// rtl/m_cd_min_sec.sv - MM:SS BCD countdown timer with run/pause/done control
module m_cd_min_sec
  import timer_pkg::*;
#(
  parameter int SEC_HI_MAX = 5,
  parameter int MIN_HI_MAX = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] ld_min_high,
  input  logic [3:0] ld_min_low,
  input  logic [3:0] ld_sec_high,
  input  logic [3:0] ld_sec_low,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] min_high,
  output logic [3:0] min_low,
  output logic [3:0] sec_high,
  output logic [3:0] sec_low,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam logic [3:0] SH_MAX = 4'(SEC_HI_MAX);
  localparam logic [3:0] MH_MAX = 4'(MIN_HI_MAX);

  state_t state;
  state_t next_state;

  logic       load_en;
  logic       dec_en;
  logic       count_zero;
  logic       count_one;
  logic       borrow_sl;
  logic       borrow_sh;
  logic       borrow_ml;
  logic       borrow_mh;
  logic [3:0] cl_min_high;
  logic [3:0] cl_min_low;
  logic [3:0] cl_sec_high;
  logic [3:0] cl_sec_low;

  assign cl_min_high = bcd_clamp(ld_min_high, MH_MAX);
  assign cl_min_low  = bcd_clamp(ld_min_low, BCD_MAX);
  assign cl_sec_high = bcd_clamp(ld_sec_high, SH_MAX);
  assign cl_sec_low  = bcd_clamp(ld_sec_low, BCD_MAX);

  assign count_zero = (min_high == 4'd0) && (min_low == 4'd0) &&
                      (sec_high == 4'd0) && (sec_low == 4'd0);
  assign count_one  = (min_high == 4'd0) && (min_low == 4'd0) &&
                      (sec_high == 4'd0) && (sec_low == 4'd1);

  // RUN is only entered with a nonzero count and left on reaching zero,
  // so the chain can never be asked to decrement 00:00.
  assign load_en = load && (state != RUN);
  assign dec_en  = (state == RUN) && tick && !pause;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      done  <= (state == RUN) && (next_state == DONE);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, PAUSE: begin
        if (load) begin
          next_state = IDLE;
        end else if (pause) begin
          next_state = state;
        end else if (start && !count_zero) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (pause) begin
          next_state = PAUSE;
        end else if (tick && count_one) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (load) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign running = (state == RUN);
  assign alarm   = (state == DONE);

  bcd_down_digit #(.WRAP(BCD_MAX)) u_sec_low (
    .clk        (clk),
    .rst_n      (rst_n),
    .dec_in     (dec_en),
    .load       (load_en),
    .ld_val     (cl_sec_low),
    .digit      (sec_low),
    .borrow_out (borrow_sl)
  );

  bcd_down_digit #(.WRAP(SH_MAX)) u_sec_high (
    .clk        (clk),
    .rst_n      (rst_n),
    .dec_in     (borrow_sl),
    .load       (load_en),
    .ld_val     (cl_sec_high),
    .digit      (sec_high),
    .borrow_out (borrow_sh)
  );

  bcd_down_digit #(.WRAP(BCD_MAX)) u_min_low (
    .clk        (clk),
    .rst_n      (rst_n),
    .dec_in     (borrow_sh),
    .load       (load_en),
    .ld_val     (cl_min_low),
    .digit      (min_low),
    .borrow_out (borrow_ml)
  );

  bcd_down_digit #(.WRAP(MH_MAX)) u_min_high (
    .clk        (clk),
    .rst_n      (rst_n),
    .dec_in     (borrow_ml),
    .load       (load_en),
    .ld_val     (cl_min_high),
    .digit      (min_high),
    .borrow_out (borrow_mh)
  );

  // The top digit's borrow would only fire below 00:00, which cannot occur.
  logic unused_borrow;
  assign unused_borrow = borrow_mh;

endmodule

// File: tb/tb_m_cd_min_sec.sv
// tb/tb_m_cd_min_sec.sv - scoreboard bench for the MM:SS countdown timer
module tb_m_cd_min_sec;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       load;
  logic [3:0] ld_min_high, ld_min_low, ld_sec_high, ld_sec_low;
  logic       start;
  logic       pause;
  logic [3:0] min_high, min_low, sec_high, sec_low;
  logic       running, done, alarm;

  m_cd_min_sec #(.SEC_HI_MAX(5), .MIN_HI_MAX(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .load        (load),
    .ld_min_high (ld_min_high),
    .ld_min_low  (ld_min_low),
    .ld_sec_high (ld_sec_high),
    .ld_sec_low  (ld_sec_low),
    .start       (start),
    .pause       (pause),
    .min_high    (min_high),
    .min_low     (min_low),
    .sec_high    (sec_high),
    .sec_low     (sec_low),
    .running     (running),
    .done        (done),
    .alarm       (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] digits;
    logic        running;
    logic        done;
    logic        alarm;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_cyc  = 0;

  // Reference model: the count is plain seconds; the mode is a small integer.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_secs = 0;
  int m_mode = M_IDLE;
  bit m_done = 0;

  function automatic int lim(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic exp_t model_step(input bit r, input bit ld, input int mh, input int ml,
                                      input int sh, input int sl, input bit st,
                                      input bit pa, input bit tk);
    exp_t e;
    int   mm, ss;
    m_done = 0;
    if (!r) begin
      m_secs = 0;
      m_mode = M_IDLE;
    end else if (m_mode == M_RUN) begin
      if (pa) m_mode = M_PAUSE;
      else if (tk) begin
        m_secs = m_secs - 1;
        if (m_secs == 0) begin
          m_mode = M_DONE;
          m_done = 1;
        end
      end
    end else if (ld) begin
      m_secs = (lim(mh, 5) * 10 + lim(ml, 9)) * 60 + lim(sh, 5) * 10 + lim(sl, 9);
      m_mode = M_IDLE;
    end else if (m_mode != M_DONE && !pa && st && m_secs != 0) begin
      m_mode = M_RUN;
    end
    mm = m_secs / 60;
    ss = m_secs % 60;
    e.digits  = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    e.running = (m_mode == M_RUN);
    e.done    = m_done;
    e.alarm   = (m_mode == M_DONE);
    return e;
  endfunction

  task automatic cyc(input bit r, input bit ld, input int mh, input int ml, input int sh,
                     input int sl, input bit st, input bit pa, input bit tk);
    @(negedge clk);
    rst_n       = r;
    load        = ld;
    ld_min_high = 4'(mh);
    ld_min_low  = 4'(ml);
    ld_sec_high = 4'(sh);
    ld_sec_low  = 4'(sl);
    start       = st;
    pause       = pa;
    tick        = tk;
    sb.push_back(model_step(r, ld, mh, ml, sh, sl, st, pa, tk));
  endtask

  task automatic idle_c();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ld_c(input int mh, input int ml, input int sh, input int sl);
    cyc(1, 1, mh, ml, sh, sl, 0, 0, 0);
  endtask

  task automatic start_c();
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
      idle_c();
    end
  endtask

  // Monitor: every cycle the DUT presents one registered output word.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cyc++;
        n_cmp++;
        if ({min_high, min_low, sec_high, sec_low} !== e.digits) begin
          n_fail++;
          $display("FAIL digits cyc=%0d got=%h required=%h", n_cyc,
                   {min_high, min_low, sec_high, sec_low}, e.digits);
        end
        n_cmp++;
        if (running !== e.running) begin
          n_fail++;
          $display("FAIL running cyc=%0d got=%b required=%b", n_cyc, running, e.running);
        end
        n_cmp++;
        if (done !== e.done) begin
          n_fail++;
          $display("FAIL done cyc=%0d got=%b required=%b", n_cyc, done, e.done);
        end
        n_cmp++;
        if (alarm !== e.alarm) begin
          n_fail++;
          $display("FAIL alarm cyc=%0d got=%b required=%b", n_cyc, alarm, e.alarm);
        end
      end
    end
  end

  initial begin
    int r;
    rst_n = 0; tick = 0; load = 0; start = 0; pause = 0;
    ld_min_high = 0; ld_min_low = 0; ld_sec_high = 0; ld_sec_low = 0;

    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_c();

    // Reset in the middle of a run at 12:34.
    ld_c(1, 2, 3, 4); start_c(); ticks(3);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle_c(); ticks(1);

    // 01:00 full run, then ticks past zero.
    ld_c(0, 1, 0, 0); start_c(); ticks(62);

    // 10:00 borrow, then clamped load.
    ld_c(1, 0, 0, 0); start_c(); ticks(1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
    ld_c(0, 0, 7, 12); idle_c();
    ld_c(15, 15, 15, 15); idle_c();

    // Pause with a simultaneous tick, ticks in PAUSE, start+pause in PAUSE.
    ld_c(0, 0, 0, 5); start_c(); idle_c();
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1);
    ticks(3);
    cyc(1, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 1);
    ticks(6);

    // Start with zero count; load during RUN.
    ld_c(0, 0, 0, 0); start_c(); ticks(1);
    ld_c(0, 3, 0, 0); start_c(); ticks(1);
    cyc(1, 1, 0, 1, 1, 1, 0, 0, 1);
    ticks(2);

    // Leave DONE by reloading.
    ld_c(0, 0, 0, 1); start_c(); ticks(2);
    ld_c(0, 0, 0, 2); idle_c(); start_c(); ticks(3);

    // Random traffic, weighted toward short counts so DONE is reached often.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 199);
      cyc((r != 199), (r < 4),
          ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : 0,
          ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 0,
          $urandom_range(0, 15), $urandom_range(0, 15),
          (r >= 4 && r < 20), (r >= 20 && r < 26), ($urandom_range(0, 2) == 0));
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d left required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
